// File: rtl/twobitup_sched.sv
// Round-robin trigger scheduler sharing one up-count datapath between two requesters.
// It grants one-cycle triggers, keeps registered counts a/b and flags their wrap-around.
module twobitup_sched #(
   parameter int CNT_W = 2,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             clr,
   output logic             gnt0,
   output logic             gnt1,
   output logic             t,
   output logic             sel,
   output logic [CNT_W-1:0] a,
   output logic [CNT_W-1:0] b,
   output logic             wrap0,
   output logic             wrap1,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   localparam int               GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [3:0]       GAP_LOAD = 4'(GAP_M1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             sel_q, sel_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] a_q, a_d;
   logic [CNT_W-1:0] b_q, b_d;
   logic             wrap0_q, wrap0_d;
   logic             wrap1_q, wrap1_d;
   logic             pick;
   logic             inc_a;
   logic             inc_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= 1'b0;
         sel_q     <= 1'b0;
         gap_cnt_q <= 4'd0;
         a_q       <= '0;
         b_q       <= '0;
         wrap0_q   <= 1'b0;
         wrap1_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         gap_cnt_q <= gap_cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         wrap0_q   <= wrap0_d;
         wrap1_q   <= wrap1_d;
      end
   end

   // With both requests pending the pointer decides; otherwise the lone requester wins.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      gap_cnt_d = gap_cnt_q;
      pick      = (req0 && req1) ? ptr_q : req1;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               sel_d   = pick;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            ptr_d = ~sel_q;
            if (GAP > 0) begin
               state_d   = S_GAP;
               gap_cnt_d = GAP_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A clear wins over a same-cycle increment and suppresses its wrap pulse.
   always_comb begin
      inc_a   = (state_q == S_GRANT) && !sel_q;
      inc_b   = (state_q == S_GRANT) && sel_q;
      a_d     = a_q;
      b_d     = b_q;
      wrap0_d = 1'b0;
      wrap1_d = 1'b0;
      if (clr) begin
         a_d = '0;
         b_d = '0;
      end else begin
         if (inc_a) begin
            a_d     = a_q + 1'b1;
            wrap0_d = (a_q == CNT_MAX);
         end
         if (inc_b) begin
            b_d     = b_q + 1'b1;
            wrap1_d = (b_q == CNT_MAX);
         end
      end
   end

   always_comb begin
      gnt0  = (state_q == S_GRANT) && !sel_q;
      gnt1  = (state_q == S_GRANT) && sel_q;
      t     = (state_q == S_GRANT);
      busy  = (state_q != S_IDLE);
      sel   = sel_q;
      a     = a_q;
      b     = b_q;
      wrap0 = wrap0_q;
      wrap1 = wrap1_q;
   end

endmodule

// File: doc/twobitup_sched.md
# twobitup_sched

Round-robin trigger scheduler that shares one 2-bit up-count datapath between two requesters. Each request wins a one-cycle trigger pulse `t` aimed at counter `a` (requester 0) or counter `b` (requester 1). The block keeps registered copies of both counts and flags wrap-around. It sits between the request sources and the `twobitup` counter pair, replacing the free-running trigger.

## Interface
Parameters:
- `CNT_W`, default 2: width of each count.
- `GAP`, default 1: number of idle cycles forced after every grant. Legal range is 0..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`  in  1  level request from requester 0 to increment `a`.
- `req1`  in  1  level request from requester 1 to increment `b`.
- `clr`  in  1  synchronous clear of both counts.
- `gnt0`  out  1  one-cycle grant to requester 0.
- `gnt1`  out  1  one-cycle grant to requester 1.
- `t`  out  1  one-cycle trigger to the datapath; equals `gnt0 | gnt1`.
- `sel`  out  1  target of the current or last trigger: 0 = `a`, 1 = `b`.
- `a`  out  CNT_W  count of granted requester-0 triggers, modulo 2^CNT_W.
- `b`  out  CNT_W  count of granted requester-1 triggers, modulo 2^CNT_W.
- `wrap0`  out  1  one-cycle pulse when `a` wraps from max to 0.
- `wrap1`  out  1  one-cycle pulse when `b` wraps from max to 0.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, GRANT, GAP.
- Priority pointer `ptr` (1 bit) names the requester favoured next.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester `ptr` names.
  - Any grant: latch `sel` and go to GRANT.
- GRANT, exactly one cycle:
  - Assert `gnt[sel]` and `t`.
  - At the closing edge, increment `a` or `b` per `sel`, and set `ptr` to `~sel`.
  - Next state is GAP if `GAP > 0`, else IDLE.
- GAP: hold for `GAP` cycles on an internal down-counter, then go to IDLE. Requests are ignored during GAP.
- Requests are level-sensitive and are not latched. A requester that holds `req` high is granted again after the gap. Two held requests alternate 0,1,0,1...
- Arithmetic: counts wrap modulo 2^CNT_W. `wrapN` pulses in the cycle after the edge that takes the count from 2^CNT_W−1 to 0.
- `clr`:
  - Sets `a` and `b` to 0 at the next edge.
  - Wins over a same-cycle increment; that increment is lost and no wrap pulse is produced.
  - Does not affect the FSM, `ptr`, or grants.
- Reset (asynchronous, any state): state IDLE, `ptr` = 0, `sel` = 0, `a` = `b` = 0. All pulses (`gnt0`, `gnt1`, `t`, `wrap0`, `wrap1`) and `busy` go low immediately. An in-flight GRANT is dropped and its count is not applied.

## Timing
- Reset values: every output is 0.
- All outputs are decoded from registers only. There is no combinational path from `req*` or `clr` to any output.
- Latency: `req` high before edge k, with the FSM in IDLE, gives `gnt`/`t` high for the cycle after edge k. The count updates at edge k+1.
- Request throughput: one grant per `GAP+2` cycles. With `GAP=0`, the FSM spends one IDLE cycle between grants.
- Handshake: requester N treats `gntN` as acceptance. It must drop `reqN` by the edge after `gntN` if it wants no further grant.
- Simultaneous requests arriving when `ptr`=0: requester 0 is granted first and requester 1 `GAP+2` cycles later.
- `busy` rises with GRANT and falls on entry to IDLE.

## Test plan
- Reset release, no requests, 10 cycles: all outputs stay 0 and `busy`=0. Assert reset mid-GRANT: `t` drops at once and `a` is unchanged.
- Single pulse on `req0`, `GAP=1`: `gnt0`/`t` high for exactly 1 cycle, `sel`=0, `a`=1, `busy` high for 2 cycles.
- `req0` and `req1` held high for 12 cycles, `GAP=1`: grant order is 0,1,0,1 at 3-cycle spacing, ending with `a`=2 and `b`=2.
- `req1` held for 4 grants: `b` counts 1,2,3,0, `wrap1` pulses once after the 3→0 edge, and `wrap0` stays 0.
- `clr` asserted in the same cycle as the GRANT for `a` (with `a`=2): `a`=0 afterwards, no `wrap0` pulse, and the FSM still advances to GAP.
- `GAP=0`, `req0` held: a grant occurs every 2 cycles, `t` is never high on two consecutive cycles, and `a` increments once per grant.
